mux_scan_ctrl: RTL and testbench
================================

# mux_scan_ctrl

Upstream sequencer for the 4:1 channel mux stage: drives the mux's 2-bit select `s`, holds each channel for a fixed dwell time, and captures the mux output `z` at the end of each dwell. After a full scan, the four captured bits are presented as one 4-bit `sample` word with a single-cycle `valid` strobe. Supports single-shot and free-running scanning.

## Interface
- `DWELL`, default 4: clock cycles per channel; legal range 2..256.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  scan request; sampled only in IDLE.
- `continuous`  in  1  when 1, the next scan starts immediately after each completed scan; sampled at every scan start.
- `mask`  in  4  channel skip mask, bit i = skip channel i; present only with `MUX_SCAN_MASK_EN`.
- `z`  in  1  mux output for the currently selected channel.
- `s`  out  2  mux select.
- `sample`  out  4  last completed scan; bit i = channel i.
- `valid`  out  1  one-cycle pulse when `sample` updates.
- `busy`  out  1  high while a scan is in progress.

## Operation
- Reset values: `s`=0, `sample`=0, `valid`=0, `busy`=0; state IDLE; dwell counter 0; shadow register 0.
- States:
  - IDLE: `busy`=0. `start`=1 moves to SCAN at the first enabled channel with the counter at 0.
  - SCAN: `busy`=1. The counter increments every cycle.
    - At counter = DWELL-1, `z` is written into shadow bit `s`, the counter clears, and `s` advances to the next enabled channel in ascending order.
    - After channel 3, or the last enabled channel, the capture completes the scan.
- Scan completion, on the same edge as the final capture:
  - `sample` takes the shadow contents, including the final bit.
  - `valid` goes high for the following cycle.
  - The shadow clears.
  - If `continuous`=1, the FSM stays in SCAN at the first enabled channel and the counter restarts. Otherwise it returns to IDLE and `s` returns to 0.
- `start` while `busy`=1 is ignored and is not queued.
- Dropping `continuous` mid-scan lets the current scan finish, then the FSM stops.
- Dwell counter width is $clog2(DWELL). The counter never exceeds DWELL-1.
- `z` is used combinationally, sampled on the capture edge only. It is not registered.
- Reset mid-scan: the partial scan is discarded, `sample` clears to 0, and no `valid` is generated.

## Timing
- `start` sampled high at edge k:
  - `s`=0 and `busy`=1 from edge k.
  - Channel i is captured at edge k+(i+1)·DWELL.
  - `sample` and `valid` update at edge k+4·DWELL.
- Latency from start to `valid` is 4·DWELL cycles with all channels enabled.
- In continuous mode, `valid` repeats every 4·DWELL cycles with no idle gap. `s` wraps 3→0 on the completion edge.
- In single-shot mode, `busy` falls on the same edge that `valid` rises.
- A new `start` is accepted from the cycle in which `valid`=1.

## Configuration
- `MUX_SCAN_MASK_EN` defined:
  - The `mask` port exists and is sampled at each scan start.
  - Masked channels take zero cycles and read as 0 in `sample`.
  - Scan length is (number of enabled channels)·DWELL.
  - All channels masked: the scan completes one cycle after start, with `sample`=0 and one `valid` pulse. In continuous mode this repeats every cycle.
- Macro undefined: there is no `mask` port, and all four channels are always scanned.

## Structure
- Package `mux_scan_pkg` holds:
  - `NUM_CH`=4 and `SEL_W`=2.
  - The state typedef `scan_state_t` {IDLE, SCAN}.
  - A helper function returning the next enabled channel for a given select and mask.
- One sub-module, `dwell_counter`:
  - Parameterised by DWELL.
  - Inputs: `clk`, `reset`, `clr`, `en`.
  - Output: `terminal` (counter = DWELL-1).

## Test plan
- Reset, then idle for 10 cycles -> `s`=0, `sample`=0, `valid`=0, `busy`=0 throughout.
- DWELL=4, pattern c=4'b1010 driven into a behavioural mux, single start -> `valid` exactly 16 cycles later, `sample`=4'b1010, `s` steps 0,1,2,3 with 4 cycles each, `busy` low afterwards.
- `continuous`=1, c changes from 4'b0011 to 4'b1100 mid-second-scan -> first `valid` gives 4'b0011, `valid` pulses spaced 16 cycles apart, a later scan gives 4'b1100.
- `start` pulsed again 5 cycles into a scan -> ignored; exactly one `valid`, at cycle 16.
- `reset` asserted at cycle 9 of a scan -> all outputs 0 next cycle and no `valid`; a new start gives a full 16-cycle scan.
- `MUX_SCAN_MASK_EN`, mask=4'b0101, c=4'b1111 -> `s` visits 1 then 3, `valid` after 8 cycles, `sample`=4'b1010. With mask=4'b1111 -> `valid` 1 cycle after start, `sample`=0.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared constants, FSM state type and channel-walk helper for mux_scan_ctrl.
package mux_scan_pkg;
   localparam int NUM_CH = 4;
   localparam int SEL_W = 2;
   typedef enum logic {IDLE, SCAN} scan_state_t;
   // Lowest unmasked channel at or above 'from'; MSB set when no such channel exists.
   function automatic logic [SEL_W:0] next_ch(input logic [SEL_W:0] from, input logic [NUM_CH-1:0] mask);
      logic [SEL_W:0] r;
      r = {1'b1, {SEL_W{1'b0}}};
      for (int i = NUM_CH - 1; i >= 0; i--)
         if ((SEL_W + 1)'(i) >= from && !mask[i]) r = (SEL_W + 1)'(i);
      return r;
   endfunction
endpackage

// File: rtl/mux_scan_ctrl_dwell_counter.sv
// dwell_counter: counts cycles spent on one channel, flags the last cycle of the dwell.
module dwell_counter #(
   parameter int DWELL = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic terminal
);
   localparam int W = $clog2(DWELL);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
   assign terminal = cnt_q == W'(DWELL - 1);
endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 4:1 mux select, captures z per channel, emits a 4-bit sample word.
// MUX_SCAN_MASK_EN adds a per-channel skip mask port.
module mux_scan_ctrl
   import mux_scan_pkg::*;
#(
   parameter int DWELL = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              continuous,
`ifdef MUX_SCAN_MASK_EN
   input  logic [NUM_CH-1:0] mask,
`endif
   input  logic              z,
   output logic [SEL_W-1:0]  s,
   output logic [NUM_CH-1:0] sample,
   output logic              valid,
   output logic              busy
);
   scan_state_t       state_q, state_d;
   logic [SEL_W-1:0]  s_q, s_d;
   logic [NUM_CH-1:0] shadow_q, shadow_d, sample_q, sample_d, mask_q, mask_d;
   logic              valid_q, valid_d, busy_q, busy_d;
   logic [NUM_CH-1:0] m_in, cap_word;
   logic [SEL_W:0]    nxt, first;
   logic              terminal, all_off, done;
`ifdef MUX_SCAN_MASK_EN
   assign m_in = mask;
`else
   assign m_in = '0;
`endif
   assign all_off = &mask_q;
   dwell_counter #(.DWELL(DWELL)) u_dwell (
      .clk      (clk),
      .reset    (reset),
      .clr      (state_q == IDLE || terminal || all_off),
      .en       (1'b1),
      .terminal (terminal)
   );
   always_comb begin
      state_d  = state_q;
      s_d      = s_q;
      shadow_d = shadow_q;
      sample_d = sample_q;
      valid_d  = 1'b0;
      busy_d   = busy_q;
      mask_d   = mask_q;
      nxt      = next_ch({1'b0, s_q} + 1'b1, mask_q);
      first    = next_ch('0, m_in);
      cap_word = shadow_q | (NUM_CH'(z) << s_q);
      done     = all_off || (terminal && nxt[SEL_W]);
      if (state_q == IDLE) begin
         if (start) begin
            state_d = SCAN;
            s_d     = first[SEL_W] ? '0 : first[SEL_W-1:0];
            busy_d  = 1'b1;
            mask_d  = m_in;
         end
      end else if (done) begin
         sample_d = all_off ? '0 : cap_word;
         valid_d  = 1'b1;
         shadow_d = '0;
         // A set continuous at completion starts the next scan on the same edge.
         if (continuous) begin
            s_d    = first[SEL_W] ? '0 : first[SEL_W-1:0];
            mask_d = m_in;
         end else begin
            state_d = IDLE;
            s_d     = '0;
            busy_d  = 1'b0;
         end
      end else if (terminal) begin
         shadow_d = cap_word;
         s_d      = nxt[SEL_W-1:0];
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         s_q      <= '0;
         shadow_q <= '0;
         sample_q <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         mask_q   <= '0;
      end else begin
         state_q  <= state_d;
         s_q      <= s_d;
         shadow_q <= shadow_d;
         sample_q <= sample_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         mask_q   <= mask_d;
      end
   end
   assign s      = s_q;
   assign sample = sample_q;
   assign valid  = valid_q;
   assign busy   = busy_q;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: directed and random scans against a cycle-count reference model.
module tb_mux_scan_ctrl;
   localparam int D = 4;
   logic       clk = 1'b0;
   logic       reset, start, continuous, z, valid, busy;
   logic [1:0] s;
   logic [3:0] sample, c, exp_sample;
   int         total = 0, bad = 0;
`ifdef MUX_SCAN_MASK_EN
   logic [3:0] mask;
`endif
   always #5 clk = ~clk;
   assign z = c[s];
   mux_scan_ctrl #(.DWELL(D)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .continuous (continuous),
`ifdef MUX_SCAN_MASK_EN
      .mask       (mask),
`endif
      .z          (z),
      .s          (s),
      .sample     (sample),
      .valid      (valid),
      .busy       (busy)
   );
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask
   // Model: edge n after start captures channel n/D-1 when n is a multiple of D;
   // every 4*D edges a scan completes, and continues only if continuous is high then.
   task automatic run(input int ncyc, input logic [3:0] ca, input logic [3:0] cb,
                      input int sw, input int drop, input int restart);
      logic [3:0] sh;
      bit act, done;
      int ch;
      sh = '0;
      act = 1'b1;
      c = ca;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_s", 4'(s), 4'd0);
      chk("start_busy", 4'(busy), 4'd1);
      for (int n = 1; n <= ncyc; n++) begin
         if (n == sw) c = cb;
         if (n == drop) continuous = 1'b0;
         start = (n == restart);
         done = 1'b0;
         if (act && n % D == 0) begin
            ch = (n / D - 1) % 4;
            sh[ch] = c[ch];
            done = (n % (4 * D) == 0);
         end
         tick();
         start = 1'b0;
         if (done) begin
            exp_sample = sh;
            sh = '0;
            act = continuous;
         end
         chk("valid", 4'(valid), 4'(done));
         chk("sample", sample, exp_sample);
         chk("busy", 4'(busy), 4'(act));
         chk("sel", 4'(s), act ? 4'((n / D) % 4) : 4'd0);
      end
   endtask
   initial begin
      reset = 1'b1;
      start = 1'b0;
      continuous = 1'b0;
      c = '0;
      exp_sample = '0;
`ifdef MUX_SCAN_MASK_EN
      mask = '0;
`endif
      tick();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_s", 4'(s), 4'd0);
         chk("idle_sample", sample, 4'd0);
         chk("idle_valid", 4'(valid), 4'd0);
         chk("idle_busy", 4'(busy), 4'd0);
      end
      run(4 * D + 2, 4'b1010, 4'b1010, -1, -1, -1);
      continuous = 1'b1;
      run(12 * D + 2, 4'b0011, 4'b1100, 5 * D + 2, 10 * D, -1);
      run(4 * D + 2, 4'b0110, 4'b0110, -1, -1, 5);
      c = 4'b1001;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (8) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_s", 4'(s), 4'd0);
      chk("rst_sample", sample, 4'd0);
      chk("rst_valid", 4'(valid), 4'd0);
      chk("rst_busy", 4'(busy), 4'd0);
      for (int i = 0; i < 2 * D; i++) begin
         tick();
         chk("post_rst_valid", 4'(valid), 4'd0);
         chk("post_rst_busy", 4'(busy), 4'd0);
      end
      exp_sample = '0;
      run(4 * D + 2, 4'b1001, 4'b1001, -1, -1, -1);
      for (int r = 0; r < 3; r++)
         run(4 * D + 2, 4'($urandom), 4'($urandom), $urandom_range(1, 4 * D), -1, -1);
      continuous = 1'b1;
      run(12 * D + 2, 4'($urandom), 4'($urandom), $urandom_range(1, 8 * D), $urandom_range(8 * D + 1, 12 * D), -1);
`ifdef MUX_SCAN_MASK_EN
      continuous = 1'b0;
      mask = 4'b0101;
      c = 4'b1111;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("m_start_s", 4'(s), 4'd1);
      for (int n = 1; n <= 2 * D; n++) begin
         tick();
         chk("m_valid", 4'(valid), 4'(n == 2 * D));
         chk("m_sel", 4'(s), n < D ? 4'd1 : n < 2 * D ? 4'd3 : 4'd0);
         chk("m_busy", 4'(busy), 4'(n < 2 * D));
      end
      chk("m_sample", sample, 4'b1010);
      mask = 4'b1111;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("all_off_valid0", 4'(valid), 4'd0);
      chk("all_off_busy", 4'(busy), 4'd1);
      tick();
      chk("all_off_valid1", 4'(valid), 4'd1);
      chk("all_off_sample", sample, 4'd0);
      chk("all_off_idle", 4'(busy), 4'd0);
      mask = '0;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
